// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and forwarding controller for the in-order pipeline. It keeps a
//   small shift-register tracker of the instructions in flight from E onward
//   (idx 0 = E, idx 1 = M, ..., idx DEPTH-1 = W). From that tracker it
//   produces:
//   - load-use stalls
//   - branch-redirect flushes
//   - a global freeze while data memory is busy
//   - the E-stage operand forwarding selects
//
// Parameters
//   DEPTH      tracked stages from E onward (3..6)
//   LOAD_STAGE first tracker index where load data can be forwarded
//              (1..DEPTH-1)
//   REG_AW     register address width
//   CNT_W      performance counter width
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   id_*               D-stage instruction fields (valid, sources,
//                      use flags, rd, regwrite, is_load)
//   ex_redirect        E-stage taken branch/jump
//   dmem_busy          data memory not ready, freeze everything
//   stall_f, stall_d   hold PC / IF-ID register
//   flush_d, flush_e   bubble IF-ID / ID-EX register
//   adv_e              enable for ID/EX, EX/MEM, MEM/WB registers
//   fwd_a_sel          E operand A source: 0 = regfile, j = tracker idx j
//   fwd_b_sel          E operand B source, same encoding
//   stall_cnt          cycles spent in load-use stall (saturating)
//   flush_cnt          redirects applied (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     ex_redirect,
  input  logic                     dmem_busy,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     adv_e,
  output logic [$clog2(DEPTH)-1:0] fwd_a_sel,
  output logic [$clog2(DEPTH)-1:0] fwd_b_sel,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              ld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1u;
    logic              rs2u;
  } trk_t;

  // Per-cycle decision, highest priority first: busy > redirect > luse > normal.
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_LUSE     = 2'd1,
    MODE_REDIRECT = 2'd2,
    MODE_BUSY     = 2'd3
  } mode_t;

  trk_t             r_trk [DEPTH];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  trk_t             w_new;
  logic             w_luse;
  mode_t            w_mode;

  // x0 is hardwired zero, so an entry targeting x0 never produces a value.
  function automatic logic f_writes(input trk_t e, input logic [REG_AW-1:0] r);
    return e.vld && e.wen && (e.rd == r) && (r != '0);
  endfunction

  // Load-use: a load at idx k reaches idx k+1 when the consumer enters E.
  // It must therefore be held back while k+1 is still short of LOAD_STAGE.
  always_comb begin
    w_luse = 1'b0;
    for (int k = 0; k < LOAD_STAGE - 1; k++) begin
      if (r_trk[k].ld &&
          ((id_rs1_used && f_writes(r_trk[k], id_rs1)) ||
           (id_rs2_used && f_writes(r_trk[k], id_rs2)))) begin
        w_luse = 1'b1;
      end
    end
    w_luse = w_luse & id_valid;
  end

  always_comb begin
    if (dmem_busy)        w_mode = MODE_BUSY;
    else if (ex_redirect) w_mode = MODE_REDIRECT;
    else if (w_luse)      w_mode = MODE_LUSE;
    else                  w_mode = MODE_NORMAL;
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    adv_e   = 1'b1;
    case (w_mode)
      MODE_BUSY: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        adv_e   = 1'b0;
      end
      MODE_REDIRECT: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      MODE_LUSE: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  // Forward selects come from registered tracker state only. Scanning from
  // the oldest entry downward leaves the youngest (lowest j) match in place.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int j = DEPTH - 1; j >= 1; j--) begin
      if (r_trk[0].rs1u && f_writes(r_trk[j], r_trk[0].rs1) &&
          (!r_trk[j].ld || j >= LOAD_STAGE)) begin
        fwd_a_sel = SEL_W'(j);
      end
      if (r_trk[0].rs2u && f_writes(r_trk[j], r_trk[0].rs2) &&
          (!r_trk[j].ld || j >= LOAD_STAGE)) begin
        fwd_b_sel = SEL_W'(j);
      end
    end
  end

  always_comb begin
    w_new      = '0;
    w_new.vld  = id_valid;
    w_new.rd   = id_rd;
    w_new.wen  = id_regwrite;
    w_new.ld   = id_is_load;
    w_new.rs1  = id_rs1;
    w_new.rs2  = id_rs2;
    w_new.rs1u = id_rs1_used;
    w_new.rs2u = id_rs2_used;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_trk[j] <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_mode != MODE_BUSY) begin
      for (int j = 1; j < DEPTH; j++) r_trk[j] <= r_trk[j-1];
      if (w_mode == MODE_NORMAL) r_trk[0] <= w_new;
      else                       r_trk[0] <= '0;
      if (w_mode == MODE_REDIRECT && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_mode == MODE_LUSE && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Two instances share one stimulus stream: a default-parameter controller
//   (DEPTH=3, LOAD_STAGE=2) and a deep one (DEPTH=5, LOAD_STAGE=4).
//   Each cycle the expected control vector
//     {stall_f, stall_d, flush_d, flush_e, adv_e, fwd_a_sel, fwd_b_sel}
//   is pushed when the inputs are driven. It is popped and compared against
//   the selected instance before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, dmem_busy;

  logic        sf3, sd3, fd3, fe3, ae3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fc3;
  logic        sf5, sd5, fd5, fe5, ae5;
  logic [2:0]  fa5, fb5;
  logic [15:0] sc5, fc5;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        use5 = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .dmem_busy(dmem_busy), .stall_f(sf3), .stall_d(sd3), .flush_d(fd3), .flush_e(fe3),
    .adv_e(ae3), .fwd_a_sel(fa3), .fwd_b_sel(fb3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  hazard_ctrl #(.DEPTH(5), .LOAD_STAGE(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .dmem_busy(dmem_busy), .stall_f(sf5), .stall_d(sd5), .flush_d(fd5), .flush_e(fe5),
    .adv_e(ae5), .fwd_a_sel(fa5), .fwd_b_sel(fb5), .stall_cnt(sc5), .flush_cnt(fc5)
  );

  logic [10:0] obs3, obs5;
  assign obs3 = {sf3, sd3, fd3, fe3, ae3, 1'b0, fa3, 1'b0, fb3};
  assign obs5 = {sf5, sd5, fd5, fe5, ae5, fa5, fb5};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ev(input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic ae, input int fa, input int fb);
    logic [2:0] a;
    logic [2:0] b;
    a = fa[2:0];
    b = fb[2:0];
    return {sf, sd, fd, fe, ae, a, b};
  endfunction

  localparam logic [10:0] NORM  = 11'b00001_000_000;
  localparam logic [10:0] LUSE  = 11'b11011_000_000;
  localparam logic [10:0] RESET = 11'b00001_000_000;

  task automatic d_nop();
    id_valid = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
  endtask

  task automatic d_ins(input int rd, input logic ld, input int rs1, input logic u1,
                       input int rs2, input logic u2);
    id_valid = 1; id_rd = rd[4:0]; id_regwrite = 1; id_is_load = ld;
    id_rs1 = rs1[4:0]; id_rs1_used = u1; id_rs2 = rs2[4:0]; id_rs2_used = u2;
  endtask

  // Inputs are already driven (just after a rising edge): record the
  // expectation, compare mid-cycle, then move past the next rising edge.
  task automatic step(input string tag, input logic [10:0] e);
    logic [10:0] x;
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check_val(tag, use5 ? {21'd0, obs5} : {21'd0, obs3}, {21'd0, x});
    end
    @(posedge clk); #1;
  endtask

  task automatic nops(input int n);
    d_nop();
    for (int i = 0; i < n; i++) step("nop", NORM);
  endtask

  task automatic do_reset();
    rst_n = 0;
    d_nop(); ex_redirect = 0; dmem_busy = 0;
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_out3", {21'd0, obs3}, {21'd0, RESET});
    check_val("rst_out5", {21'd0, obs5}, {21'd0, RESET});
    check_val("rst_cnt3", {sc3, fc3}, 32'd0);
    check_val("rst_cnt5", {sc5, fc5}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // Back-to-back ALU dependency forwards from M.
    d_ins(5, 0, 1, 1, 2, 1); step("t1_add5", NORM);
    d_ins(6, 0, 5, 1, 2, 1); step("t1_add6_d", NORM);
    d_nop();                 step("t1_fwd_a1", ev(0, 0, 0, 0, 1, 1, 0));
    nops(2);

    // Two producers of x5: youngest (idx 1) wins on both operands.
    d_ins(5, 0, 0, 0, 0, 0); step("t1b_p1", NORM);
    d_ins(5, 0, 1, 1, 1, 1); step("t1b_p2", NORM);
    d_ins(7, 0, 5, 1, 5, 1); step("t1b_use", NORM);
    d_nop();                 step("t1b_fwd_ab1", ev(0, 0, 0, 0, 1, 1, 1));

    // Producer two slots ahead forwards from W on operand B.
    d_ins(9, 0, 0, 0, 0, 0); step("t1c_p", NORM);
    d_nop();                 step("t1c_gap", NORM);
    d_ins(8, 0, 3, 1, 9, 1); step("t1c_use", NORM);
    d_nop();                 step("t1c_fwd_b2", ev(0, 0, 0, 0, 1, 0, 2));
    nops(2);

    // Redirect in the same cycle a load-use would fire: flush wins.
    d_ins(5, 1, 1, 1, 0, 0); step("t3_lw", NORM);
    d_ins(7, 0, 5, 1, 0, 0); ex_redirect = 1;
    step("t3_redirect", ev(0, 0, 1, 1, 1, 0, 0));
    ex_redirect = 0; d_nop(); step("t3_after", NORM);
    check_val("t3_stall_cnt", {16'd0, sc3}, 32'd0);
    check_val("t3_flush_cnt", {16'd0, fc3}, 32'd1);
    nops(2);

    // Load-use: one stall cycle, then forward from W.
    d_ins(5, 1, 1, 1, 0, 0); step("t2_lw", NORM);
    d_ins(7, 0, 5, 1, 6, 1); step("t2_stall", LUSE);
    step("t2_release", NORM);
    d_nop(); step("t2_fwd_a2", ev(0, 0, 0, 0, 1, 2, 0));
    check_val("t2_stall_cnt", {16'd0, sc3}, 32'd1);
    nops(2);

    // Memory busy for four cycles with a redirect waiting in E.
    d_ins(5, 0, 0, 0, 0, 0); step("t4_add5", NORM);
    d_ins(6, 0, 5, 1, 0, 0); step("t4_add6", NORM);
    d_ins(9, 0, 0, 0, 0, 0); dmem_busy = 1; ex_redirect = 1;
    for (int i = 0; i < 4; i++) step("t4_busy", ev(1, 1, 0, 0, 0, 1, 0));
    check_val("t4_flush_hold", {16'd0, fc3}, 32'd1);
    dmem_busy = 0; step("t4_redirect", ev(0, 0, 1, 1, 1, 1, 0));
    ex_redirect = 0; d_nop(); step("t4_after", NORM);
    check_val("t4_flush_cnt", {16'd0, fc3}, 32'd2);
    check_val("t4_stall_cnt", {16'd0, sc3}, 32'd1);
    nops(2);

    // x0 neither forwards nor stalls.
    d_ins(0, 0, 0, 0, 0, 0); step("t5_add_x0", NORM);
    d_ins(1, 0, 0, 1, 0, 1); step("t5_use_x0", NORM);
    d_nop();                 step("t5_nofwd", NORM);
    d_ins(0, 1, 2, 1, 0, 0); step("t5_lw_x0", NORM);
    d_ins(2, 0, 0, 1, 0, 1); step("t5_nostall", NORM);
    d_nop();                 step("t5_nofwd_ld", NORM);
    check_val("t5_stall_cnt", {16'd0, sc3}, 32'd1);

    // Deep pipeline: load usable from idx 4, so three stall cycles.
    do_reset();
    use5 = 1'b1;
    d_ins(3, 1, 1, 1, 0, 0); step("t6_lw", NORM);
    d_ins(4, 0, 3, 1, 2, 1);
    for (int i = 0; i < 3; i++) step("t6_stall", LUSE);
    step("t6_release", NORM);
    d_nop(); step("t6_fwd_a4", ev(0, 0, 0, 0, 1, 4, 0));
    check_val("t6_stall_cnt", {16'd0, sc5}, 32'd3);
    nops(5);

    // Asynchronous reset in the middle of a load-use stall.
    d_ins(3, 1, 1, 1, 0, 0); step("t7_lw", NORM);
    d_ins(4, 0, 3, 1, 0, 0); step("t7_stall1", LUSE);
    exp_q.push_back(LUSE);
    #2;
    check_val("t7_stall2", {21'd0, obs5}, {21'd0, exp_q.pop_front()});
    rst_n = 0;
    #1;
    check_val("t7_rst_out", {21'd0, obs5}, {21'd0, RESET});
    check_val("t7_rst_cnt", {sc5, fc5}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    d_nop(); step("t7_post", NORM);

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
